// File: rtl/color_blend_stage_pkg.sv
// Shared definitions for the color blend stage: channel positions, alpha test
// and blend factor codes, and the helpers that decode them.
package color_blend_stage_pkg;

    localparam int COLOR_W     = 32;
    localparam int COLOR_R_POS = 24;
    localparam int COLOR_G_POS = 16;
    localparam int COLOR_B_POS = 8;
    localparam int COLOR_A_POS = 0;

    localparam logic [2:0] ALPHA_NEVER    = 3'd0;
    localparam logic [2:0] ALPHA_LESS     = 3'd1;
    localparam logic [2:0] ALPHA_EQUAL    = 3'd2;
    localparam logic [2:0] ALPHA_LEQUAL   = 3'd3;
    localparam logic [2:0] ALPHA_GREATER  = 3'd4;
    localparam logic [2:0] ALPHA_NOTEQUAL = 3'd5;
    localparam logic [2:0] ALPHA_GEQUAL   = 3'd6;
    localparam logic [2:0] ALPHA_ALWAYS   = 3'd7;

    localparam logic [3:0] BF_ZERO                = 4'd0;
    localparam logic [3:0] BF_ONE                 = 4'd1;
    localparam logic [3:0] BF_SRC_COLOR           = 4'd2;
    localparam logic [3:0] BF_ONE_MINUS_SRC_COLOR = 4'd3;
    localparam logic [3:0] BF_DST_COLOR           = 4'd4;
    localparam logic [3:0] BF_ONE_MINUS_DST_COLOR = 4'd5;
    localparam logic [3:0] BF_SRC_ALPHA           = 4'd6;
    localparam logic [3:0] BF_ONE_MINUS_SRC_ALPHA = 4'd7;
    localparam logic [3:0] BF_DST_ALPHA           = 4'd8;
    localparam logic [3:0] BF_ONE_MINUS_DST_ALPHA = 4'd9;
    localparam logic [3:0] BF_SRC_ALPHA_SATURATE  = 4'd10;

    // Unsigned alpha comparison selected by the alpha function code.
    function automatic logic alpha_test(input logic [2:0] fn,
                                        input logic [7:0] a,
                                        input logic [7:0] aref);
        case (fn)
            ALPHA_NEVER:    return 1'b0;
            ALPHA_LESS:     return a <  aref;
            ALPHA_EQUAL:    return a == aref;
            ALPHA_LEQUAL:   return a <= aref;
            ALPHA_GREATER:  return a >  aref;
            ALPHA_NOTEQUAL: return a != aref;
            ALPHA_GEQUAL:   return a >= aref;
            default:        return 1'b1;
        endcase
    endfunction

    // Per-channel blend factor; unknown codes (11..15) resolve to zero.
    function automatic logic [7:0] blend_factor(input logic [3:0] code,
                                                input logic [7:0] cs,
                                                input logic [7:0] cd,
                                                input logic [7:0] as_v,
                                                input logic [7:0] ad_v,
                                                input logic       is_alpha);
        logic [7:0] sat;
        sat = (as_v < (8'hFF - ad_v)) ? as_v : (8'hFF - ad_v);
        case (code)
            BF_ZERO:                return 8'h00;
            BF_ONE:                 return 8'hFF;
            BF_SRC_COLOR:           return cs;
            BF_ONE_MINUS_SRC_COLOR: return 8'hFF - cs;
            BF_DST_COLOR:           return cd;
            BF_ONE_MINUS_DST_COLOR: return 8'hFF - cd;
            BF_SRC_ALPHA:           return as_v;
            BF_ONE_MINUS_SRC_ALPHA: return 8'hFF - as_v;
            BF_DST_ALPHA:           return ad_v;
            BF_ONE_MINUS_DST_ALPHA: return 8'hFF - ad_v;
            BF_SRC_ALPHA_SATURATE:  return is_alpha ? 8'hFF : sat;
            default:                return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/color_blend_stage_if.sv
// Fragment stream into and out of the blend stage.
interface color_blend_stage_if
    import color_blend_stage_pkg::*;
#(
    parameter int TAG_WIDTH = 32
);
    logic                 s_valid;
    logic [TAG_WIDTH-1:0] s_tag;
    logic [COLOR_W-1:0]   s_color;
    logic [COLOR_W-1:0]   s_dst_color;
    logic                 m_valid;
    logic                 m_write;
    logic [TAG_WIDTH-1:0] m_tag;
    logic [COLOR_W-1:0]   m_color;

    modport master (
        output s_valid, s_tag, s_color, s_dst_color,
        input  m_valid, m_write, m_tag, m_color
    );

    modport slave (
        input  s_valid, s_tag, s_color, s_dst_color,
        output m_valid, m_write, m_tag, m_color
    );
endinterface

// File: rtl/color_blend_stage_mul255.sv
// Registered 8x8 multiply normalized by 255 with round-to-nearest.
module color_mul255 (
    input  logic       clk_i,
    input  logic       ce_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);
    // (t + t>>8) >> 8 with t = a*b + 128 equals round(a*b/255) exactly.
    function automatic logic [7:0] mul_round(input logic [7:0] a, input logic [7:0] b);
        logic [16:0] t;
        logic [16:0] u;
        t = 17'(a) * 17'(b) + 17'd128;
        u = t + (t >> 8);
        return 8'(u >> 8);
    endfunction

    logic [7:0] p_q;

    // Product register; pure datapath, so no reset.
    always_ff @(posedge clk_i) begin
        if (ce_i) p_q <= mul_round(a_i, b_i);
    end

    assign p_o = p_q;
endmodule

// File: rtl/color_blend_stage.sv
// Alpha test and framebuffer blend: three enabled cycles from s_* to m_*,
// frozen entirely while ce is low.
module color_blend_stage
    import color_blend_stage_pkg::*;
#(
    parameter int SUB_PIXEL_WIDTH = 8,
    parameter int TAG_WIDTH       = 32
)(
    input  logic       aclk,
    input  logic       resetn,
    input  logic       ce,
    color_blend_stage_if.slave bus,
    input  logic [2:0] confAlphaFunc,
    input  logic [7:0] confAlphaRef,
    input  logic       confBlendEnable,
    input  logic [3:0] confSrcFactor,
    input  logic [3:0] confDstFactor
);
    localparam int CW    = SUB_PIXEL_WIDTH;
    localparam int NCH   = 4;
    localparam int A_IDX = COLOR_A_POS / CW;

    // Channel sum clamped to full scale.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    logic [NCH-1:0][CW-1:0] src_ch, dst_ch;
    assign src_ch = bus.s_color;
    assign dst_ch = bus.s_dst_color;

    logic                   pass_p1_d;
    logic [NCH-1:0][CW-1:0] sf_p1_d, df_p1_d;

    logic                   vld_p1_q, pass_p1_q;
    logic [TAG_WIDTH-1:0]   tag_p1_q;
    logic [NCH-1:0][CW-1:0] src_p1_q, dst_p1_q, sf_p1_q, df_p1_q;
    logic                   blend_p1_q;

    logic                   vld_p2_q, pass_p2_q;
    logic [TAG_WIDTH-1:0]   tag_p2_q;
    logic [NCH-1:0][CW-1:0] src_p2_q;
    logic                   blend_p2_q;
    logic [NCH-1:0][CW-1:0] s_p2, d_p2;

    logic [NCH-1:0][CW-1:0] m_color_d;
    logic                   m_valid_q, m_write_q;
    logic [TAG_WIDTH-1:0]   m_tag_q;
    logic [NCH-1:0][CW-1:0] m_color_q;

    // Stage 1 decode: alpha test qualified by valid, factors resolved per channel.
    always_comb begin
        pass_p1_d = bus.s_valid & alpha_test(confAlphaFunc, src_ch[A_IDX], confAlphaRef);
        sf_p1_d   = '0;
        df_p1_d   = '0;
        for (int i = 0; i < NCH; i++) begin
            sf_p1_d[i] = blend_factor(confSrcFactor, src_ch[i], dst_ch[i],
                                      src_ch[A_IDX], dst_ch[A_IDX], i == A_IDX);
            df_p1_d[i] = blend_factor(confDstFactor, src_ch[i], dst_ch[i],
                                      src_ch[A_IDX], dst_ch[A_IDX], i == A_IDX);
        end
    end

    // Stage 2 multiplies: source and destination terms for every channel.
    for (genvar i = 0; i < NCH; i++) begin : g_mul
        color_mul255 u_src_mul (
            .clk_i (aclk),
            .ce_i  (ce),
            .a_i   (src_p1_q[i]),
            .b_i   (sf_p1_q[i]),
            .p_o   (s_p2[i])
        );
        color_mul255 u_dst_mul (
            .clk_i (aclk),
            .ce_i  (ce),
            .a_i   (dst_p1_q[i]),
            .b_i   (df_p1_q[i]),
            .p_o   (d_p2[i])
        );
    end

    // Stage 3 sum with saturation, or the untouched source color when bypassed.
    always_comb begin
        m_color_d = src_p2_q;
        if (blend_p2_q) begin
            for (int i = 0; i < NCH; i++) m_color_d[i] = sat_add(s_p2[i], d_p2[i]);
        end
    end

    // Valid/pass chain and output registers; reset discards in-flight fragments.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            vld_p1_q  <= 1'b0;
            pass_p1_q <= 1'b0;
            vld_p2_q  <= 1'b0;
            pass_p2_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_write_q <= 1'b0;
            m_tag_q   <= '0;
            m_color_q <= '0;
        end else if (ce) begin
            vld_p1_q  <= bus.s_valid;
            pass_p1_q <= pass_p1_d;
            vld_p2_q  <= vld_p1_q;
            pass_p2_q <= pass_p1_q;
            m_valid_q <= vld_p2_q;
            m_write_q <= pass_p2_q;
            m_tag_q   <= tag_p2_q;
            m_color_q <= m_color_d;
        end
    end

    // Internal datapath registers; contents of invalid slots are don't-care.
    always_ff @(posedge aclk) begin
        if (ce) begin
            tag_p1_q   <= bus.s_tag;
            src_p1_q   <= src_ch;
            dst_p1_q   <= dst_ch;
            sf_p1_q    <= sf_p1_d;
            df_p1_q    <= df_p1_d;
            blend_p1_q <= confBlendEnable;
            tag_p2_q   <= tag_p1_q;
            src_p2_q   <= src_p1_q;
            blend_p2_q <= blend_p1_q;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_write = m_write_q;
    assign bus.m_tag   = m_tag_q;
    assign bus.m_color = m_color_q;

endmodule

// File: doc/color_blend_stage.md
# color_blend_stage

Per-fragment alpha test and framebuffer blending stage that sits directly downstream of the fog stage. It consumes the fogged {R,G,B,A} color and the matching destination color read from the color buffer. It produces the final color and a write qualifier for the framebuffer writer. The stage is a fixed-latency, 3-cycle pipeline with a global clock-enable stall. It has the same latency discipline as the rest of the fragment pipeline.

## Interface
Parameters:
- SUB_PIXEL_WIDTH, 8, channel width; only 8 is supported.
- TAG_WIDTH, 32, width of the opaque fragment tag (framebuffer index) carried alongside the fragment.

Ports:
- aclk  in  1  clock; all state is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ce  in  1  pipeline enable; 0 freezes every register.
- s_valid  in  1  the input fragment is valid this cycle.
- s_tag  in  TAG_WIDTH  fragment tag; passed through unchanged.
- s_color  in  32  source color from fog: R[31:24], G[23:16], B[15:8], A[7:0].
- s_dst_color  in  32  destination color, same packing.
- confAlphaFunc  in  3  alpha test function: 0 NEVER, 1 LESS, 2 EQUAL, 3 LEQUAL, 4 GREATER, 5 NOTEQUAL, 6 GEQUAL, 7 ALWAYS.
- confAlphaRef  in  8  alpha test reference value.
- confBlendEnable  in  1  0 bypasses blending; the output equals s_color.
- confSrcFactor, confDstFactor  in  4 each  blend factor codes: 0 ZERO, 1 ONE, 2 SRC_COLOR, 3 ONE_MINUS_SRC_COLOR, 4 DST_COLOR, 5 ONE_MINUS_DST_COLOR, 6 SRC_ALPHA, 7 ONE_MINUS_SRC_ALPHA, 8 DST_ALPHA, 9 ONE_MINUS_DST_ALPHA, 10 SRC_ALPHA_SATURATE. Codes 11–15 are treated as ZERO.
- m_valid  out  1  an output fragment is present.
- m_write  out  1  the fragment passed the alpha test and must be written.
- m_tag  out  TAG_WIDTH  delayed s_tag.
- m_color  out  32  blended color.

## Operation
- Stage 1 (register inputs):
  - Alpha test: compare s_color[7:0] against confAlphaRef, unsigned, using confAlphaFunc.
  - Pass bit: pass = result AND s_valid.
  - Resolve per-channel source and destination factors:
    - ONE = 0xFF; ONE_MINUS_x = 0xFF − x.
    - SRC_ALPHA_SATURATE: RGB factor = min(As, 0xFF − Ad); alpha factor = 0xFF.
    - The factor set is legal for both the source and destination roles.
- Stage 2 (multiply): for every channel, S = mul(src_c, sf_c) and D = mul(dst_c, df_c).
  - mul(a,b): t = a*b + 128 (17 bit); result = (t + (t>>8)) >> 8.
  - This is exact round-to-nearest of a*b/255, so mul(x,0xFF) = x and mul(x,0) = 0.
- Stage 3 (sum): each channel = min(S + D, 0xFF), using a 9-bit sum with saturation.
- Bypass: with confBlendEnable = 0, m_color = s_color delayed 3 cycles, bit-exact.
- Alpha test with blending: the test runs regardless of confBlendEnable. A failing fragment still emits m_valid = 1 with m_write = 0, so the downstream counters stay aligned.
- Configuration timing: conf* signals are sampled in stage 1 together with the fragment. The driver changes conf* only while the pipeline is drained; behaviour on a mid-flight change is per-fragment-at-capture.

## Timing
- Latency: exactly 3 enabled (ce = 1) cycles from s_* to m_*. Throughput is one fragment per enabled cycle.
- Stall: ce = 0 holds all data and valid registers. Outputs stay stable and input is ignored. No bubbles are inserted or lost.
- Reset values: m_valid = 0, m_write = 0, m_color = 0, m_tag = 0. All internal valid and pass bits = 0.
- Reset mid-operation: every in-flight fragment is discarded. After resetn rises, the first m_valid appears 3 enabled cycles after the first s_valid.
- Invalid slots: when s_valid = 0, the slot propagates with m_valid = 0 and m_write = 0. The data registers may update, but their value is don't-care.
- Saturation boundary: 0xFF + 0xFF → 0xFF; 0x00 + 0x00 → 0x00.

## Structure
- The shared package (register/descriptor defines) holds:
  - the alpha function codes,
  - the blend factor codes,
  - the COLOR_R/G/B/A_POS positions, already defined there.
- One sub-module, color_mul255: registered 8×8 → 8 normalized multiply, instantiated 8 times (RGBA × src/dst).

## Test plan
- ONE/ONE blending, src 0xC0C0C0C0, dst 0x80808080 → m_color 0xFFFFFFFF (saturated), m_write = 1, exactly 3 cycles later.
- SRC_ALPHA/ONE_MINUS_SRC_ALPHA, src 0x80808080, dst 0xFF000000 → m_color 0xBF404040.
- Alpha GREATER with ref 0x80, src alpha 0x80 → m_valid = 1, m_write = 0. With src alpha 0x81 → m_write = 1.
- Blend disabled, random src/dst for 1000 fragments with random ce gaps → m_color equals s_color in order, and the tags match.
- Stall: ce held low for 5 cycles with 3 fragments in flight → outputs frozen, no fragment lost or duplicated.
- Reset asserted with a full pipeline → m_valid = 0 immediately (asynchronous) and stays 0 until new input arrives.
